cache_initiator: RTL and testbench
==================================

Name: cache_initiator

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting between the CPU port and the memory controller (mux_controler).
- Acts as the initiator of the controller protocol:
  - drives signal_controller, controller_running, wb_address and cache_data_output;
  - consumes done and cache_data_input.
- Single-word lines; tag, valid and dirty arrays are held in registers.

Parameters:
- ADDR_W, 5: address width, matching the controller.
- DATA_W, 3: data word width.
- INDEX_W, 2: index bits, giving 2^INDEX_W lines; tag width is ADDR_W-INDEX_W.
- CNT_W, 8: width of the hit and miss statistic counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  one-cycle request strobe; accepted only in IDLE.
- cpu_write  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_address  in  ADDR_W  request address; sampled with cpu_req.
- cpu_wdata  in  DATA_W  write data; sampled with cpu_req.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in every state other than IDLE.
- signal_controller  out  3  request code to the controller.
- controller_running  out  1  one-cycle start pulse to the controller.
- wb_address  out  ADDR_W  victim write-back address.
- cache_data_output  out  DATA_W  victim or write data sent to memory.
- instruction_address  out  ADDR_W  fill address (the latched cpu_address).
- cache_data_input  in  DATA_W  fill data; valid when done=1.
- done  in  1  controller completion pulse.
- hit_count, miss_count  out  CNT_W  saturating statistic counters.

Behaviour:
Reset (reset_n=0 at a clock edge):
- All valid and dirty bits are cleared.
- All outputs go to 0 and the FSM goes to IDLE.
- The counters are cleared.
- Reset mid-transaction abandons it. Any done received outside WAIT is ignored.

Request codes:
- 000: read miss, victim clean.
- 001: read miss, victim dirty.
- 011: write miss, victim dirty.
- 111: write-through store (optional feature only).

FSM states: IDLE, LOOKUP, REQ, WAIT, FILL, RESP.
- IDLE:
  - On cpu_req, latch write, address and wdata, then go to LOOKUP.
- LOOKUP: compare the tag at the index.
  - Read hit: cpu_rdata = line data, then RESP. Latency is 2 cycles from cpu_req to cpu_done.
  - Write hit: update data, set dirty, then RESP.
  - Read miss: code 001 if the victim is valid and dirty, else 000. Go to REQ.
  - Write miss with a dirty victim: code 011, then REQ.
  - Write miss with a clean victim: install tag and data, set valid and dirty, then RESP. No memory traffic.
- REQ:
  - controller_running = 1 for exactly one cycle.
  - wb_address = {victim tag, index}; cache_data_output = victim data.
  - Then go to WAIT.
- WAIT:
  - Hold signal_controller, wb_address, cache_data_output and instruction_address stable.
  - controller_running = 0. Wait on done with no fixed latency; there is no timeout.
- FILL, entered on done:
  - Read miss: write cache_data_input into the line, tag = latched tag, valid = 1, dirty = 0. cpu_rdata = cache_data_input.
  - Write miss: install the latched wdata, valid = 1, dirty = 1.
  - Then go to RESP.
- RESP:
  - cpu_done = 1 for one cycle, then IDLE.

Timing and counting rules:
- cpu_req outside IDLE is ignored. A CPU agent must wait for cpu_busy=0.
- controller_running is never asserted while a transaction is outstanding. At least one idle cycle follows done before the next pulse.
- hit_count increments in LOOKUP on a hit; miss_count increments on a miss. Both saturate at all ones.
- Index = address[INDEX_W-1:0]; tag = the upper bits.

Optional Feature:
- CACHE_WRITE_THROUGH_EN defined:
  - Every write (hit or miss) updates or installs the line clean (dirty = 0).
  - It then issues code 111 with wb_address = cpu_address and cache_data_output = wdata, and waits for done before RESP.
  - Dirty bits are never set, so codes 001 and 011 never occur.
- Undefined: write-back behaviour as above; code 111 is never emitted.

Decomposition:
- Package cache_pkg holds:
  - request code constants (RD_MISS_CLEAN, RD_MISS_DIRTY, WR_MISS_DIRTY, WR_THROUGH);
  - the FSM state enum;
  - the default widths.
- One natural sub-module: cache_tag_array, holding the valid, dirty, tag and data registers with a single read/write port and synchronous clear.

Test Plan:
- Reset, then read 0x05: code 000, one controller_running pulse; on done, cache_data_input=3'b110, then cpu_rdata=110 and miss_count=1.
- Re-read 0x05 -> no controller pulse; cpu_done 2 cycles after cpu_req; cpu_rdata=110; hit_count=1.
- Write 0x05 with 3'b011 (hit), then read 0x0D (same index) -> code 001, wb_address=0x05, cache_data_output=011; fill completes the read.
- Write 0x0A with 101 (clean miss), then write 0x12 with 010 (same index) -> code 011, wb_address=0x0A, cache_data_output=101; line now holds 0x12 dirty.
- Assert reset_n=0 while in WAIT -> all lines invalid and outputs zero; a late done pulse is ignored; the next read of 0x05 misses with code 000.
- With CACHE_WRITE_THROUGH_EN, write 0x03 with 111 -> code 111, wb_address=0x03, cache_data_output=111; a later miss on index 3 uses code 000.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache initiator: default widths,
// controller request codes and the transaction FSM state encoding.
package cache_pkg;

  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 3;
  localparam int DEF_INDEX_W = 2;
  localparam int DEF_CNT_W   = 8;
  localparam int CODE_W      = 3;

  localparam logic [CODE_W-1:0] RD_MISS_CLEAN = 3'b000;
  localparam logic [CODE_W-1:0] RD_MISS_DIRTY = 3'b001;
  localparam logic [CODE_W-1:0] WR_MISS_DIRTY = 3'b011;
  localparam logic [CODE_W-1:0] WR_THROUGH    = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_WAIT,
    ST_FILL,
    ST_RESP
  } state_t;

  function automatic logic [CODE_W-1:0] read_miss_code(input logic victim_dirty);
    return victim_dirty ? RD_MISS_DIRTY : RD_MISS_CLEAN;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Per-line valid/dirty/tag/data registers with one combinational read port,
// one write port (indexed by the same address) and synchronous clear.
module cache_tag_array #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic              valid_w [LINES];
  logic              dirty_w [LINES];
  logic [TAG_W-1:0]  tag_w   [LINES];
  logic [DATA_W-1:0] data_w  [LINES];

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic              valid_reg;
    logic              dirty_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        valid_reg <= 1'b0;
        dirty_reg <= 1'b0;
        tag_reg   <= '0;
        data_reg  <= '0;
      end else if (wr_en && (index == INDEX_W'(gi))) begin
        valid_reg <= 1'b1;
        dirty_reg <= wr_dirty;
        tag_reg   <= wr_tag;
        data_reg  <= wr_data;
      end
    end

    assign valid_w[gi] = valid_reg;
    assign dirty_w[gi] = dirty_reg;
    assign tag_w[gi]   = tag_reg;
    assign data_w[gi]  = data_reg;
  end

  assign rd_valid = valid_w[index];
  assign rd_dirty = dirty_w[index];
  assign rd_tag   = tag_w[index];
  assign rd_data  = data_w[index];

endmodule

// File: rtl/cache_initiator.sv
// Direct-mapped write-back/write-allocate cache driving the memory controller protocol.
// Define CACHE_WRITE_THROUGH_EN to make every store write-through (code 111, lines stay clean).
module cache_initiator
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic [CODE_W-1:0] signal_controller,
  output logic              controller_running,
  output logic [ADDR_W-1:0] wb_address,
  output logic [DATA_W-1:0] cache_data_output,
  output logic [ADDR_W-1:0] instruction_address,
  input  logic [DATA_W-1:0] cache_data_input,
  input  logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W;

`ifdef CACHE_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  state_t            state_reg,    state_next;
  logic              write_reg,    write_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [DATA_W-1:0] wdata_reg,    wdata_next;
  logic [CODE_W-1:0] code_reg,     code_next;
  logic [ADDR_W-1:0] wb_addr_reg,  wb_addr_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [DATA_W-1:0] rdata_reg,    rdata_next;
  logic [CNT_W-1:0]  hit_cnt_reg,  hit_cnt_next;
  logic [CNT_W-1:0]  miss_cnt_reg, miss_cnt_next;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               tag_wr_en, tag_wr_dirty;
  logic [DATA_W-1:0]  tag_wr_data;
  logic               line_hit, victim_dirty;

  assign req_index = addr_reg[INDEX_W-1:0];
  assign req_tag   = addr_reg[ADDR_W-1:INDEX_W];

  cache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_tag_array (
    .clock    (clock),
    .reset_n  (reset_n),
    .index    (req_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (tag_wr_en),
    .wr_dirty (tag_wr_dirty),
    .wr_tag   (req_tag),
    .wr_data  (tag_wr_data)
  );

  assign line_hit     = rd_valid && (rd_tag == req_tag);
  assign victim_dirty = rd_valid && rd_dirty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      code_reg     <= RD_MISS_CLEAN;
      wb_addr_reg  <= '0;
      out_data_reg <= '0;
      rdata_reg    <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      write_reg    <= write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      code_reg     <= code_next;
      wb_addr_reg  <= wb_addr_next;
      out_data_reg <= out_data_next;
      rdata_reg    <= rdata_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    code_next     = code_reg;
    wb_addr_next  = wb_addr_reg;
    out_data_next = out_data_reg;
    rdata_next    = rdata_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    tag_wr_en     = 1'b0;
    tag_wr_dirty  = 1'b0;
    tag_wr_data   = wdata_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (cpu_req) begin
          write_next = cpu_write;
          addr_next  = cpu_address;
          wdata_next = cpu_wdata;
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (line_hit) begin
          if (hit_cnt_reg != '1) hit_cnt_next = hit_cnt_reg + CNT_W'(1);
        end else if (miss_cnt_reg != '1) begin
          miss_cnt_next = miss_cnt_reg + CNT_W'(1);
        end
        if (!write_reg) begin
          if (line_hit) begin
            rdata_next = rd_data;
            state_next = ST_RESP;
          end else begin
            code_next     = read_miss_code(victim_dirty);
            wb_addr_next  = {rd_tag, req_index};
            out_data_next = rd_data;
            state_next    = ST_REQ;
          end
        end else if (WRITE_THROUGH) begin
          // Line is updated clean now; memory gets the store via code 111.
          tag_wr_en     = 1'b1;
          code_next     = WR_THROUGH;
          wb_addr_next  = addr_reg;
          out_data_next = wdata_reg;
          state_next    = ST_REQ;
        end else if (line_hit || !victim_dirty) begin
          tag_wr_en    = 1'b1;
          tag_wr_dirty = 1'b1;
          state_next   = ST_RESP;
        end else begin
          code_next     = WR_MISS_DIRTY;
          wb_addr_next  = {rd_tag, req_index};
          out_data_next = rd_data;
          state_next    = ST_REQ;
        end
      end
      ST_REQ: state_next = ST_WAIT;
      ST_WAIT: begin
        // Fill data is only valid alongside done, so capture it here.
        if (done) begin
          if (!write_reg) rdata_next = cache_data_input;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        tag_wr_en    = 1'b1;
        tag_wr_data  = write_reg ? wdata_reg : rdata_reg;
        tag_wr_dirty = write_reg && !WRITE_THROUGH;
        state_next   = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign cpu_rdata           = rdata_reg;
  assign cpu_done            = (state_reg == ST_RESP);
  assign cpu_busy            = (state_reg != ST_IDLE);
  assign signal_controller   = code_reg;
  assign controller_running  = (state_reg == ST_REQ);
  assign wb_address          = wb_addr_reg;
  assign cache_data_output   = out_data_reg;
  assign instruction_address = addr_reg;
  assign hit_count           = hit_cnt_reg;
  assign miss_count          = miss_cnt_reg;

endmodule

// File: tb/tb_cache_initiator.sv
// Directed bench for cache_initiator; acts as CPU agent and memory controller.
// Build with CACHE_WRITE_THROUGH_EN to run the write-through scenario instead of the write-back ones.
module tb_cache_initiator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cpu_req, cpu_write;
  logic [4:0] cpu_address;
  logic [2:0] cpu_wdata, cpu_rdata;
  logic       cpu_done, cpu_busy;
  logic [2:0] signal_controller;
  logic       controller_running;
  logic [4:0] wb_address, instruction_address;
  logic [2:0] cache_data_output, cache_data_input;
  logic       done;
  logic [7:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_count = 0;

  always #5 clock = ~clock;

  cache_initiator dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .cpu_req             (cpu_req),
    .cpu_write           (cpu_write),
    .cpu_address         (cpu_address),
    .cpu_wdata           (cpu_wdata),
    .cpu_rdata           (cpu_rdata),
    .cpu_done            (cpu_done),
    .cpu_busy            (cpu_busy),
    .signal_controller   (signal_controller),
    .controller_running  (controller_running),
    .wb_address          (wb_address),
    .cache_data_output   (cache_data_output),
    .instruction_address (instruction_address),
    .cache_data_input    (cache_data_input),
    .done                (done),
    .hit_count           (hit_count),
    .miss_count          (miss_count)
  );

  always @(negedge clock) if (controller_running === 1'b1) pulse_count++;

  task automatic issue(input logic wr, input logic [4:0] addr, input logic [2:0] wd);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_write = wr; cpu_address = addr; cpu_wdata = wd;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    $display("txn %s addr=0x%02h wdata=%b", wr ? "write" : "read ", addr, wd);
  endtask

  task automatic wait_running(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (controller_running === 1'b1) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_cpu_done(output bit seen, output int cycles);
    seen = 1'b0; cycles = -1;
    for (int i = 0; i < 20; i++) begin
      if (cpu_done === 1'b1) begin seen = 1'b1; cycles = i; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic send_done(input logic [2:0] data);
    @(posedge clock); #1;
    done = 1'b1; cache_data_input = data;
    @(posedge clock); #1;
    done = 1'b0; cache_data_input = 3'b000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if ({cpu_done, cpu_busy, controller_running} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 000", {cpu_done, cpu_busy, controller_running}); end
    n_cmp++; if ({signal_controller, wb_address, cache_data_output, instruction_address, cpu_rdata} !== 19'd0) begin n_fail++;
      $display("FAIL reset_buses: got %h want 0", {signal_controller, wb_address, cache_data_output, instruction_address, cpu_rdata}); end
    n_cmp++; if ({hit_count, miss_count} !== 16'd0) begin n_fail++;
      $display("FAIL reset_counters: got %h want 0000", {hit_count, miss_count}); end
    reset_n = 1'b1;
  endtask

  task automatic test_read_miss();
    bit seen; int cyc;
    issue(1'b0, 5'h05, 3'b000);
    wait_running(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rdmiss_running: got %b want 1", seen); end
    n_cmp++; if (signal_controller !== 3'b000) begin n_fail++;
      $display("FAIL rdmiss_code: got %b want 000", signal_controller); end
    n_cmp++; if (instruction_address !== 5'h05) begin n_fail++;
      $display("FAIL rdmiss_iaddr: got %h want 05", instruction_address); end
    @(posedge clock); #1;
    n_cmp++; if ({controller_running, cpu_busy} !== 2'b01) begin n_fail++;
      $display("FAIL wait_running_busy: got %b want 01", {controller_running, cpu_busy}); end
    // a request while busy must be dropped
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 5'h1F; cpu_wdata = 3'b111;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    n_cmp++; if ({instruction_address, signal_controller} !== {5'h05, 3'b000}) begin n_fail++;
      $display("FAIL busy_req_ignored: got %h want %h", {instruction_address, signal_controller}, {5'h05, 3'b000}); end
    send_done(3'b110);
    wait_cpu_done(seen, cyc);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rdmiss_done: got %b want 1", seen); end
    n_cmp++; if (cpu_rdata !== 3'b110) begin n_fail++; $display("FAIL rdmiss_rdata: got %b want 110", cpu_rdata); end
    n_cmp++; if ({hit_count, miss_count} !== {8'd0, 8'd1}) begin n_fail++;
      $display("FAIL rdmiss_counts: got %0d/%0d want 0/1", hit_count, miss_count); end
    @(posedge clock); #1;
    n_cmp++; if ({cpu_done, cpu_busy} !== 2'b00) begin n_fail++;
      $display("FAIL done_one_cycle: got %b want 00", {cpu_done, cpu_busy}); end
  endtask

  task automatic test_read_hit();
    bit seen; int cyc; int p0;
    p0 = pulse_count;
    issue(1'b0, 5'h05, 3'b000);
    wait_cpu_done(seen, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", cyc); end
    n_cmp++; if (cpu_rdata !== 3'b110) begin n_fail++; $display("FAIL hit_rdata: got %b want 110", cpu_rdata); end
    n_cmp++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    n_cmp++; if (pulse_count !== p0) begin n_fail++; $display("FAIL hit_no_pulse: got %0d want %0d", pulse_count, p0); end
  endtask

`ifdef CACHE_WRITE_THROUGH_EN
  task automatic test_write_through();
    bit seen; int cyc;
    test_reset();
    issue(1'b1, 5'h03, 3'b111);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller, wb_address, cache_data_output} !== {1'b1, 3'b111, 5'h03, 3'b111}) begin n_fail++;
      $display("FAIL wt_req: got %b/%b/%h/%b want 1/111/03/111", seen, signal_controller, wb_address, cache_data_output); end
    send_done(3'b000);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({seen, miss_count} !== {1'b1, 8'd1}) begin n_fail++;
      $display("FAIL wt_done: got %b/%0d want 1/1", seen, miss_count); end
    issue(1'b0, 5'h03, 3'b000);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cyc, cpu_rdata} !== {32'd1, 3'b111}) begin n_fail++;
      $display("FAIL wt_hit: got %0d/%b want 1/111", cyc, cpu_rdata); end
    issue(1'b0, 5'h07, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller} !== {1'b1, 3'b000}) begin n_fail++;
      $display("FAIL wt_clean_victim: got %b/%b want 1/000", seen, signal_controller); end
    send_done(3'b001);
    wait_cpu_done(seen, cyc);
    n_cmp++; if (cpu_rdata !== 3'b001) begin n_fail++; $display("FAIL wt_fill: got %b want 001", cpu_rdata); end
  endtask
`else
  task automatic test_dirty_evict();
    bit seen; int cyc; int p0;
    p0 = pulse_count;
    issue(1'b1, 5'h05, 3'b011);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cyc, hit_count} !== {32'd1, 8'd2}) begin n_fail++;
      $display("FAIL wrhit: got %0d/%0d want 1/2", cyc, hit_count); end
    n_cmp++; if (pulse_count !== p0) begin n_fail++; $display("FAIL wrhit_no_pulse: got %0d want %0d", pulse_count, p0); end
    issue(1'b0, 5'h0D, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller} !== {1'b1, 3'b001}) begin n_fail++;
      $display("FAIL evict_code: got %b/%b want 1/001", seen, signal_controller); end
    n_cmp++; if ({wb_address, cache_data_output, instruction_address} !== {5'h05, 3'b011, 5'h0D}) begin n_fail++;
      $display("FAIL evict_bus: got %h/%b/%h want 05/011/0d", wb_address, cache_data_output, instruction_address); end
    send_done(3'b100);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({seen, cpu_rdata, miss_count} !== {1'b1, 3'b100, 8'd2}) begin n_fail++;
      $display("FAIL evict_fill: got %b/%b/%0d want 1/100/2", seen, cpu_rdata, miss_count); end
    issue(1'b0, 5'h0D, 3'b000);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cyc, cpu_rdata, hit_count} !== {32'd1, 3'b100, 8'd3}) begin n_fail++;
      $display("FAIL evict_rehit: got %0d/%b/%0d want 1/100/3", cyc, cpu_rdata, hit_count); end
  endtask

  task automatic test_write_miss();
    bit seen; int cyc; int p0;
    p0 = pulse_count;
    issue(1'b1, 5'h0A, 3'b101);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cyc, miss_count} !== {32'd1, 8'd3}) begin n_fail++;
      $display("FAIL wrmiss_clean: got %0d/%0d want 1/3", cyc, miss_count); end
    n_cmp++; if (pulse_count !== p0) begin n_fail++; $display("FAIL wrmiss_no_pulse: got %0d want %0d", pulse_count, p0); end
    issue(1'b1, 5'h12, 3'b010);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller, wb_address, cache_data_output} !== {1'b1, 3'b011, 5'h0A, 3'b101}) begin n_fail++;
      $display("FAIL wrmiss_dirty: got %b/%b/%h/%b want 1/011/0a/101", seen, signal_controller, wb_address, cache_data_output); end
    send_done(3'b111);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({seen, miss_count} !== {1'b1, 8'd4}) begin n_fail++;
      $display("FAIL wrmiss_done: got %b/%0d want 1/4", seen, miss_count); end
    issue(1'b0, 5'h12, 3'b000);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cyc, cpu_rdata, hit_count} !== {32'd1, 3'b010, 8'd4}) begin n_fail++;
      $display("FAIL wrmiss_installed: got %0d/%b/%0d want 1/010/4", cyc, cpu_rdata, hit_count); end
    issue(1'b0, 5'h0A, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller, wb_address, cache_data_output} !== {1'b1, 3'b001, 5'h12, 3'b010}) begin n_fail++;
      $display("FAIL wrmiss_line_dirty: got %b/%b/%h/%b want 1/001/12/010", seen, signal_controller, wb_address, cache_data_output); end
    send_done(3'b101);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cpu_rdata, miss_count} !== {3'b101, 8'd5}) begin n_fail++;
      $display("FAIL refill: got %b/%0d want 101/5", cpu_rdata, miss_count); end
  endtask

  task automatic test_reset_in_wait();
    bit seen; int cyc;
    issue(1'b0, 5'h1D, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller} !== {1'b1, 3'b000}) begin n_fail++;
      $display("FAIL rst_pre_code: got %b/%b want 1/000", seen, signal_controller); end
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    n_cmp++; if ({cpu_busy, cpu_done, controller_running, signal_controller, wb_address, cache_data_output, instruction_address} !== 19'd0) begin n_fail++;
      $display("FAIL rst_wait_outputs: got %h want 0", {cpu_busy, cpu_done, controller_running, signal_controller, wb_address, cache_data_output, instruction_address}); end
    n_cmp++; if ({hit_count, miss_count} !== 16'd0) begin n_fail++;
      $display("FAIL rst_wait_counters: got %h want 0000", {hit_count, miss_count}); end
    done = 1'b1; cache_data_input = 3'b111;
    @(posedge clock); #1;
    done = 1'b0; cache_data_input = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({cpu_busy, cpu_done} !== 2'b00) begin n_fail++;
        $display("FAIL late_done_ignored: got %b want 00", {cpu_busy, cpu_done}); end
      @(posedge clock); #1;
    end
    issue(1'b0, 5'h05, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller} !== {1'b1, 3'b000}) begin n_fail++;
      $display("FAIL post_rst_miss: got %b/%b want 1/000", seen, signal_controller); end
    send_done(3'b110);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cpu_rdata, miss_count} !== {3'b110, 8'd1}) begin n_fail++;
      $display("FAIL post_rst_fill: got %b/%0d want 110/1", cpu_rdata, miss_count); end
    issue(1'b0, 5'h0A, 3'b000);
    wait_running(seen);
    n_cmp++; if ({seen, signal_controller} !== {1'b1, 3'b000}) begin n_fail++;
      $display("FAIL post_rst_invalid: got %b/%b want 1/000", seen, signal_controller); end
    send_done(3'b011);
    wait_cpu_done(seen, cyc);
    n_cmp++; if ({cpu_rdata, hit_count, miss_count} !== {3'b011, 8'd0, 8'd2}) begin n_fail++;
      $display("FAIL post_rst_counts: got %b/%0d/%0d want 011/0/2", cpu_rdata, hit_count, miss_count); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_wdata = '0; done = 1'b0; cache_data_input = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
`ifdef CACHE_WRITE_THROUGH_EN
    test_write_through();
`else
    test_dirty_evict();
    test_write_miss();
    test_reset_in_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
